// File: rtl/q_byte_collector.sv
// Serial-to-parallel collector: assembles WIDTH-bit words LSB-first from the Q stream
// and presents them through a one-entry valid/ready holding register with popcount and overflow.
module q_byte_collector #(
  parameter int WIDTH = 8
) (
  input  logic                       Clk,
  input  logic                       Resetn,
  input  logic                       Q_in,
  input  logic                       En,
  input  logic                       Clr,
  input  logic                       Ready,
  output logic [WIDTH-1:0]           Data,
  output logic                       Valid,
  output logic [$clog2(WIDTH+1)-1:0] Ones,
  output logic                       Overflow,
  output logic [$clog2(WIDTH)-1:0]   Bit_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam int OW = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic logic [OW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [OW-1:0] c;
    c = {OW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      c = c + OW'(v[i]);
    end
    return c;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] sh_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] data_r;
  logic [OW-1:0]    ones_r;
  logic             ovf_r;

  logic             last_s;
  logic             complete_s;
  logic [WIDTH-1:0] word_s;
  logic             load_s;
  logic             ovf_set_s;

  assign last_s     = (cnt_r == CW'(WIDTH - 1));
  assign complete_s = En & last_s;
  assign word_s     = {Q_in, sh_r[WIDTH-1:1]};

  // Holding-register next state and load/overflow decisions
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    ovf_set_s   = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (complete_s) begin
          load_s      = 1'b1;
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (complete_s) begin
          // a simultaneous drain lets the new word replace the old one
          if (Ready) begin
            load_s = 1'b1;
          end else begin
            ovf_set_s = 1'b1;
          end
          state_nxt_s = ST_FULL;
        end else if (Ready) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // Sample shifter and bit counter; a dropped word still realigns the counter
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      sh_r  <= {WIDTH{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (Clr) begin
      sh_r  <= {WIDTH{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (En) begin
      sh_r  <= word_s;
      cnt_r <= last_s ? {CW{1'b0}} : cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Holding register, popcount and sticky overflow
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= ST_EMPTY;
      data_r  <= {WIDTH{1'b0}};
      ones_r  <= {OW{1'b0}};
      ovf_r   <= 1'b0;
    end else if (Clr) begin
      state_r <= ST_EMPTY;
      data_r  <= {WIDTH{1'b0}};
      ones_r  <= {OW{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        data_r <= word_s;
        ones_r <= popcount(word_s);
      end
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign Data     = data_r;
  assign Ones     = ones_r;
  assign Valid    = (state_r == ST_FULL);
  assign Overflow = ovf_r;
  assign Bit_cnt  = cnt_r;

endmodule
